alu: RTL and testbench

// - 32-bit combinational ALU core with registered result and flags, for the integer

---
 rtl/alu.sv | 146 ++++++++++++++
 tb/tb_alu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit integer ALU for the execute stage, with registered outputs.
//
// Purpose:
//   Computes one of sixteen operations on operand A and operand B every
//   cycle. The result and the Zero/Neg/ovfalu flags are captured on the rising
//   edge of clk. They stay stable until the next edge for the writeback and
//   branch logic. Operand B is either SrcB or a 16-bit immediate taken from
//   SrcB[15:0]. The immediate is sign-extended for arithmetic and compare
//   operations and zero-extended for all other operations.
//
// Ports:
//   clk     in   1   clock, all state updates on the rising edge
//   rst     in   1   synchronous active-high reset, clears result and flags
//   i       in   1   immediate select (1 = use extended SrcB[15:0])
//   SrcA    in   32  operand A
//   SrcB    in   32  operand B (only [15:0] used when i=1)
//   af      in   4   ALU function code
//   Alures  out  32  registered result
//   Zero    out  1   registered: result == 0
//   Neg     out  1   registered: result[31]
//   ovfalu  out  1   registered signed overflow (ADD/SUB only)
//
// Configuration:
//   ALU_MUL_EN  when defined, af=1110 returns the low 32 bits of A*Bop.
//               When undefined, af=1110 returns 0 and no multiplier is built.
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        i,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  af,
  output logic [31:0] Alures,
  output logic        Zero,
  output logic        Neg,
  output logic        ovfalu
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBU  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1101;
  localparam logic [3:0] OP_MUL   = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  logic        imm_signed;
  logic [31:0] bop;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic [31:0] res_next;
  logic        ovf_next;

  // The immediate is sign-extended only for the add/sub/compare family.
  // Logical operations, shifts and PASSB see it zero-extended.
  always_comb begin
    imm_signed = 1'b0;
    case (af)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU: imm_signed = 1'b1;
      default: imm_signed = 1'b0;
    endcase
  end

  // Select operand B. When i=1, the immediate is extended according to the op class.
  always_comb begin
    if (!i)
      bop = SrcB;
    else if (imm_signed)
      bop = {{16{SrcB[15]}}, SrcB[15:0]};
    else
      bop = {16'h0000, SrcB[15:0]};
  end

  // The adder and subtractor are shared between the signed and unsigned variants.
  // The carry-out is dropped because arithmetic is modulo 2^32.
  assign sum   = SrcA + bop;
  assign diff  = SrcA - bop;
  assign shamt = bop[4:0];

  // Result mux. Overflow is only flagged by the signed ADD and SUB variants.
  // On overflow the wrapped value is still written.
  always_comb begin
    res_next = 32'h0;
    ovf_next = 1'b0;
    case (af)
      OP_ADD: begin
        res_next = sum;
        ovf_next = (SrcA[31] == bop[31]) && (sum[31] != SrcA[31]);
      end
      OP_ADDU: res_next = sum;
      OP_SUB: begin
        res_next = diff;
        ovf_next = (SrcA[31] != bop[31]) && (diff[31] != SrcA[31]);
      end
      OP_SUBU:  res_next = diff;
      OP_AND:   res_next = SrcA & bop;
      OP_OR:    res_next = SrcA | bop;
      OP_XOR:   res_next = SrcA ^ bop;
      OP_NOR:   res_next = ~(SrcA | bop);
      OP_SLT:   res_next = {31'h0, ($signed(SrcA) < $signed(bop))};
      OP_SLTU:  res_next = {31'h0, (SrcA < bop)};
      OP_SLL:   res_next = SrcA << shamt;
      OP_SRL:   res_next = SrcA >> shamt;
      OP_SRA:   res_next = $signed(SrcA) >>> shamt;
      OP_LUI:   res_next = {SrcB[15:0], 16'h0000};
`ifdef ALU_MUL_EN
      // The low 32 bits of a signed product are the same as those of an
      // unsigned product, so a plain 32x32 multiply truncated to 32 bits suffices.
      OP_MUL:   res_next = SrcA * bop;
`else
      OP_MUL:   res_next = 32'h0;
`endif
      OP_PASSB: res_next = bop;
      default:  res_next = 32'h0;
    endcase
  end

  // Output register. Reset takes priority over whatever operation is presented.
  // Zero and Neg are taken from the final result for every operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      Alures <= 32'h0;
      Zero   <= 1'b0;
      Neg    <= 1'b0;
      ovfalu <= 1'b0;
    end else begin
      Alures <= res_next;
      Zero   <= (res_next == 32'h0);
      Neg    <= res_next[31];
      ovfalu <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// Purpose:
//   Runs directed cases for the documented corner behaviour, then a
//   randomized sweep over all function codes. Each result is checked against
//   an arithmetic reference model. The bench honours ALU_MUL_EN in the same
//   way as the design.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic        i;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  af;
  logic [31:0] Alures;
  logic        Zero;
  logic        Neg;
  logic        ovfalu;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .i      (i),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .af     (af),
    .Alures (Alures),
    .Zero   (Zero),
    .Neg    (Neg),
    .ovfalu (ovfalu)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Operand B is derived from its textual definition, and
  // ADD/SUB overflow is detected by doing the arithmetic in 64 bits and
  // testing whether the result fits in the 32-bit signed range.
  function automatic void model(input logic ii, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] f,
                                output logic [31:0] r, output logic o);
    logic [31:0] bo;
    longint      wa;
    longint      wb;
    longint      w;
    int          sh;
    bit          arith;
    arith = (f <= 4'd3) || (f == 4'd8) || (f == 4'd9);
    if (!ii)
      bo = b;
    else if (arith)
      bo = {{16{b[15]}}, b[15:0]};
    else
      bo = {16'h0, b[15:0]};
    wa = longint'($signed(a));
    wb = longint'($signed(bo));
    sh = int'(bo % 32);
    r  = 32'h0;
    o  = 1'b0;
    case (f)
      4'd0: begin
        w = wa + wb;
        r = w[31:0];
        o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      4'd1: r = a + bo;
      4'd2: begin
        w = wa - wb;
        r = w[31:0];
        o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      4'd3: r = a - bo;
      4'd4: r = a & bo;
      4'd5: r = a | bo;
      4'd6: r = a ^ bo;
      4'd7: r = ~(a | bo);
      4'd8: r = (wa < wb) ? 32'd1 : 32'd0;
      4'd9: r = (longint'(a) < longint'(bo)) ? 32'd1 : 32'd0;
      4'd10: r = 32'(longint'(a) * (64'd1 << sh));
      4'd11: r = 32'(longint'(a) / (64'd1 << sh));
      4'd12: begin
        // Arithmetic shift right modelled as floor division by 2^sh.
        w = wa / (64'sd1 << sh);
        if ((wa < 0) && (w * (64'sd1 << sh) != wa)) w = w - 1;
        r = w[31:0];
      end
      4'd13: r = {b[15:0], 16'h0};
`ifdef ALU_MUL_EN
      4'd14: begin
        w = wa * wb;
        r = w[31:0];
      end
`else
      4'd14: r = 32'h0;
`endif
      default: r = bo;
    endcase
  endfunction

  // Present one operation between clock edges, let it be captured, and
  // return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ii, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] f,
                               input logic r);
    @(negedge clk);
    i    = ii;
    SrcA = a;
    SrcB = b;
    af   = f;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  // Compare all four registered outputs with the expected values.
  task automatic checkOutput(input string tag, input logic [31:0] expRes,
                             input logic expZero, input logic expNeg,
                             input logic expOvf);
    checks++;
    assert (Alures === expRes) else begin
      errors++;
      $error("[TB] FAIL %s Alures: got %h expected %h", tag, Alures, expRes);
    end
    checks++;
    assert (Zero === expZero) else begin
      errors++;
      $error("[TB] FAIL %s Zero: got %b expected %b", tag, Zero, expZero);
    end
    checks++;
    assert (Neg === expNeg) else begin
      errors++;
      $error("[TB] FAIL %s Neg: got %b expected %b", tag, Neg, expNeg);
    end
    checks++;
    assert (ovfalu === expOvf) else begin
      errors++;
      $error("[TB] FAIL %s ovfalu: got %b expected %b", tag, ovfalu, expOvf);
    end
  endtask

  // Apply an operation with reset low and check it against the model.
  task automatic runModel(input string tag, input logic ii, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] f);
    logic [31:0] er;
    logic        eo;
    model(ii, a, b, f, er, eo);
    applyStimulus(ii, a, b, f, 1'b0);
    checkOutput(tag, er, (er == 32'h0), er[31], eo);
  endtask

  // Directed steps first, then a randomized sweep with occasional resets.
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rf;
    logic        ri;
    logic [31:0] er;
    logic        eo;
    rst  = 1'b1;
    i    = 1'b0;
    SrcA = 32'h0;
    SrcB = 32'h0;
    af   = 4'h0;

    applyStimulus(1'b0, 32'd1, 32'd2, 4'b0000, 1'b1);
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'd1, 32'd2, 4'b0000, 1'b0);
    checkOutput("add_1_2", 32'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd3, 32'd1, 4'b0010, 1'b0);
    checkOutput("sub_3_1", 32'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd5, 4'b0010, 1'b0);
    checkOutput("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd4, 32'h0000_0002, 4'b0000, 1'b0);
    checkOutput("addi_4_2", 32'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'hABCD_FFFF, 4'b0000, 1'b0);
    checkOutput("addi_sext", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'hABCD_FFFF, 4'b0101, 1'b0);
    checkOutput("ori_zext", 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0000, 1'b0);
    checkOutput("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0001, 1'b0);
    checkOutput("addu_noovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'd1, 4'b0010, 1'b0);
    checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1000, 1'b0);
    checkOutput("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1001, 1'b0);
    checkOutput("sltu_neg", 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'd4, 4'b1100, 1'b0);
    checkOutput("sra_4", 32'hF800_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h8765_4321, 32'd0, 4'b1010, 1'b0);
    checkOutput("sll_0", 32'h8765_4321, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 4'b1101, 1'b0);
    checkOutput("lui", 32'h1234_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd6, 32'd7, 4'b1110, 1'b0);
`ifdef ALU_MUL_EN
    checkOutput("mul_6_7", 32'd42, 1'b0, 1'b0, 1'b0);
`else
    checkOutput("mul_6_7", 32'd0, 1'b1, 1'b0, 1'b0);
`endif
    applyStimulus(1'b0, 32'd1, 32'd2, 4'b0000, 1'b1);
    checkOutput("reset_over_add", 32'h0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 4'($urandom_range(0, 15));
      ri = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        2: rb = 32'h8000_0000;
        3: rb = {27'h0, 5'($urandom_range(0, 31))};
        default: ;
      endcase
      if ($urandom_range(0, 24) == 0) begin
        applyStimulus(ri, ra, rb, rf, 1'b1);
        checkOutput("rand_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        model(ri, ra, rb, rf, er, eo);
        applyStimulus(ri, ra, rb, rf, 1'b0);
        checkOutput($sformatf("rand%0d_af%0d_i%0d", n, rf, ri),
                    er, (er == 32'h0), er[31], eo);
      end
    end

    runModel("final_sub_i", 1'b1, 32'h0000_0010, 32'h0000_8000, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
